// File: rtl/video_scale_up_process.sv
// video_scale_up_process: nearest-neighbour upscaler replaying one buffered line in x and y
// Define VIDEO_SCALE_UP_MARK_EN to add video_sof_out / video_eol_out pixel markers.
module video_scale_up_process #(
    parameter int PIX_DATA_WIDTH = 24,
    parameter int MAX_LINE_WIDTH = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                      video_clk,
    input  logic                      rst,
    input  logic                      frame_sync_n,
    input  logic [PIX_DATA_WIDTH-1:0] video_data_in,
    input  logic                      video_data_valid,
    output logic                      video_ready_in,
    output logic [PIX_DATA_WIDTH-1:0] video_data_out,
    output logic                      video_data_out_valid,
    input  logic                      video_ready,
    input  logic [15:0]               video_width_in,
    input  logic [15:0]               video_height_in,
    input  logic [15:0]               video_width_out,
`ifdef VIDEO_SCALE_UP_MARK_EN
    input  logic [15:0]               video_height_out,
    output logic                      video_sof_out,
    output logic                      video_eol_out
`else
    input  logic [15:0]               video_height_out
`endif
);
`ifdef VIDEO_SCALE_UP_MARK_EN
    localparam int EW = PIX_DATA_WIDTH + 2;
`else
    localparam int EW = PIX_DATA_WIDTH;
`endif
    typedef enum logic [2:0] {IDLE, CALC, FILL, EMIT, DONE} state_t;
    state_t state;
    logic [15:0] w_in, h_in, w_out, h_out;
    logic [5:0] div_cnt;
    logic [31:0] dvd;
    logic [30:0] quo;
    logic [15:0] rem;
    logic [31:0] coef_x, coef_y, acc_x, acc_y, acc_y_nx, quo_nx;
    logic [15:0] in_x, in_y, buf_row, ox_rd, ox_out, oy, divisor;
    logic [16:0] rem_sh;
    logic ge, in_fire, pop, push, issue, rd_pend;
    logic [1:0] fcnt, occ;
    logic [EW-1:0] q0, q1, rd_ent;
    logic [PIX_DATA_WIDTH-1:0] ram_q;
    logic [PIX_DATA_WIDTH-1:0] ram [MAX_LINE_WIDTH];

    always_comb begin
        divisor = div_cnt[5] ? h_out : w_out;
        rem_sh = {rem, dvd[31]};
        ge = rem_sh >= {1'b0, divisor};
        quo_nx = {quo, ge};
        in_fire = video_ready_in && video_data_valid;
        pop = video_data_out_valid && video_ready;
        push = rd_pend;
        // slots still claimed after this cycle's pop, counting the read in flight
        occ = fcnt + {1'b0, rd_pend} - {1'b0, pop};
        issue = state == EMIT && ox_rd != w_out && occ != 2'd2;
        acc_y_nx = acc_y + coef_y;
    end

    assign video_ready_in = state == FILL || state == DONE;
    assign video_data_out_valid = fcnt != 2'd0;
    assign video_data_out = q0[PIX_DATA_WIDTH-1:0];

    always_ff @(posedge video_clk) begin
        if (state == FILL && in_fire) ram[in_x[ADDR_WIDTH-1:0]] <= video_data_in;
        ram_q <= ram[acc_x[16 +: ADDR_WIDTH]];
    end

    always_ff @(posedge video_clk) begin
        if (rst || !frame_sync_n) begin
            state <= IDLE;
            {w_in, h_in, w_out, h_out} <= '0;
            {div_cnt, dvd, quo, rem} <= '0;
            {coef_x, coef_y, acc_x, acc_y} <= '0;
            {in_x, in_y, buf_row, ox_rd, ox_out, oy} <= '0;
            {rd_pend, fcnt, q0, q1} <= '0;
        end else begin
            case (state)
                IDLE: if (video_width_in != 0 && video_height_in != 0 && video_width_out != 0 &&
                          video_height_out != 0 && video_width_in <= 16'(MAX_LINE_WIDTH)) begin
                    state <= CALC;
                    {w_in, h_in, w_out, h_out} <= {video_width_in, video_height_in, video_width_out, video_height_out};
                    dvd <= {video_width_in, 16'h0};
                    {rem, quo, div_cnt} <= '0;
                end
                CALC: begin
                    div_cnt <= div_cnt + 6'd1;
                    dvd <= {dvd[30:0], 1'b0};
                    rem <= ge ? 16'(rem_sh - {1'b0, divisor}) : rem_sh[15:0];
                    quo <= quo_nx[30:0];
                    if (div_cnt == 6'd31) begin
                        coef_x <= w_in >= w_out ? 32'h1_0000 : quo_nx;
                        dvd <= {h_in, 16'h0};
                        {rem, quo} <= '0;
                    end
                    if (div_cnt == 6'd63) begin
                        coef_y <= h_in >= h_out ? 32'h1_0000 : quo_nx;
                        state <= FILL;
                    end
                end
                FILL: if (in_fire) begin
                    in_x <= in_x + 16'd1;
                    if (in_x == w_in - 16'd1) begin
                        in_x <= '0;
                        in_y <= in_y + 16'd1;
                        if (in_y == acc_y[31:16]) begin
                            state <= EMIT;
                            buf_row <= in_y;
                        end
                    end
                end
                EMIT: begin
                    if (issue) begin
                        acc_x <= acc_x + coef_x;
                        ox_rd <= ox_rd + 16'd1;
                    end
                    if (pop) begin
                        ox_out <= ox_out + 16'd1;
                        if (ox_out == w_out - 16'd1) begin
                            {ox_out, ox_rd, acc_x} <= '0;
                            oy <= oy + 16'd1;
                            acc_y <= acc_y_nx;
                            state <= oy + 16'd1 == h_out ? DONE : acc_y_nx[31:16] == buf_row ? EMIT : FILL;
                        end
                    end
                end
                default: ;
            endcase
            rd_pend <= issue;
            fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
            if (pop) q0 <= q1;
            if (push) begin
                if (fcnt == {1'b0, pop}) q0 <= rd_ent;
                else q1 <= rd_ent;
            end
        end
    end

`ifdef VIDEO_SCALE_UP_MARK_EN
    logic rd_sof, rd_eol;
    always_ff @(posedge video_clk) begin
        if (rst || !frame_sync_n) begin
            rd_sof <= 1'b0;
            rd_eol <= 1'b0;
        end else if (issue) begin
            rd_sof <= ox_rd == 16'd0 && oy == 16'd0;
            rd_eol <= ox_rd == w_out - 16'd1;
        end
    end
    assign rd_ent = {rd_sof, rd_eol, ram_q};
    assign video_sof_out = video_data_out_valid && q0[EW-1];
    assign video_eol_out = video_data_out_valid && q0[EW-2];
`else
    assign rd_ent = ram_q;
`endif
endmodule
